pipe_ctl: RTL and testbench

PIPE_CTL -- requirements
Module: pipe_ctl

---
 rtl/pipe_ctl.sv | 156 +++++++++++++++
 tb/tb_pipe_ctl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctl.sv
// Pipeline hazard control for a five-stage Y86-style core: stall/bubble generation,
// a RUN/STOP status machine and saturating performance counters.
module pipe_ctl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic [3:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] misp_cnt
);

  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPopq   = 4'hB;
  localparam logic [3:0] RNone   = 4'hF;
  localparam logic [3:0] SAok    = 4'h1;
  localparam logic [3:0] SHlt    = 4'h2;
  localparam logic [3:0] SAdr    = 4'h3;
  localparam logic [3:0] SIns    = 4'h4;

  typedef enum logic [0:0] {StRun, StStop} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cpu_stat_q, cpu_stat_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] misp_q, misp_d;

  logic load_use, ret_haz, mispredict, exc_m, exc_w, retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != '1)) r = v + CNT_W'(1);
    return r;
  endfunction

  // Hazard detection
  always_comb begin
    load_use   = ((E_icode == IMrmovq) || (E_icode == IPopq)) && (E_dstM != RNone) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_haz    = (D_icode == IRet) || (E_icode == IRet) || (M_icode == IRet);
    mispredict = (E_icode == IJxx) && !e_cnd;
    exc_m      = (m_stat == SHlt) || (m_stat == SAdr) || (m_stat == SIns);
    exc_w      = (W_stat == SHlt) || (W_stat == SAdr) || (W_stat == SIns);
    retire     = (W_stat == SAok) && (W_icode != INop);
  end

  // Control outputs; reset flush overrides everything, STOP overrides hazards.
  always_comb begin
    F_stall  = load_use | ret_haz;
    D_stall  = load_use;
    // load_use keeps the decode register held, so it must not also be bubbled
    D_bubble = (mispredict | ret_haz) & ~load_use;
    E_bubble = mispredict | load_use;
    M_bubble = exc_m | exc_w;
    W_stall  = exc_w;
    unique case (state_q)
      StStop: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end
  end

  // Next state, status and counters
  always_comb begin
    state_d    = state_q;
    cpu_stat_d = cpu_stat_q;
    halted_d   = halted_q;
    cyc_d      = cyc_q;
    ret_d      = ret_q;
    stall_d    = stall_q;
    misp_d     = misp_q;
    unique case (state_q)
      StRun: begin
        cyc_d   = sat_inc(cyc_q, 1'b1);
        ret_d   = sat_inc(ret_q, retire);
        stall_d = sat_inc(stall_q, load_use);
        misp_d  = sat_inc(misp_q, mispredict);
        if (exc_w) begin
          state_d    = StStop;
          cpu_stat_d = W_stat;
          halted_d   = 1'b1;
        end
      end
      StStop: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      cpu_stat_q <= SAok;
      halted_q   <= 1'b0;
      cyc_q      <= '0;
      ret_q      <= '0;
      stall_q    <= '0;
      misp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cpu_stat_q <= cpu_stat_d;
      halted_q   <= halted_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
      stall_q    <= stall_d;
      misp_q     <= misp_d;
    end
  end

  assign cpu_stat  = cpu_stat_q;
  assign halted    = halted_q;
  assign cyc_cnt   = cyc_q;
  assign ret_cnt   = ret_q;
  assign stall_cnt = stall_q;
  assign misp_cnt  = misp_q;

endmodule

// File: tb/tb_pipe_ctl.sv
// Bench for pipe_ctl: directed vectors with literal expectations plus a per-cycle
// comparison against a behavioural model, on a 32-bit and a 4-bit counter instance.
module tb_pipe_ctl;

  logic       clk, rst;
  logic [3:0] D_icode, E_icode, M_icode, W_icode;
  logic [3:0] d_srcA, d_srcB, E_dstM;
  logic       e_cnd;
  logic [3:0] m_stat, W_stat;

  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
  logic [3:0]  cpu_stat;
  logic        halted;
  logic [31:0] cyc_cnt, ret_cnt, stall_cnt, misp_cnt;

  logic       F_stall_s, D_stall_s, W_stall_s, D_bubble_s, E_bubble_s, M_bubble_s;
  logic [3:0] cpu_stat_s;
  logic       halted_s;
  logic [3:0] cyc_s, ret_s, stall_s, misp_s;

  logic [5:0] ctl, ctl_s;
  assign ctl   = {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble};
  assign ctl_s = {F_stall_s, D_stall_s, W_stall_s, D_bubble_s, E_bubble_s, M_bubble_s};

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  pipe_ctl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .W_icode(W_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .cpu_stat(cpu_stat), .halted(halted), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
    .stall_cnt(stall_cnt), .misp_cnt(misp_cnt)
  );

  pipe_ctl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .W_icode(W_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall_s), .D_stall(D_stall_s),
    .W_stall(W_stall_s), .D_bubble(D_bubble_s), .E_bubble(E_bubble_s),
    .M_bubble(M_bubble_s), .cpu_stat(cpu_stat_s), .halted(halted_s), .cyc_cnt(cyc_s),
    .ret_cnt(ret_s), .stall_cnt(stall_s), .misp_cnt(misp_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] satv(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  // Behavioural model: counts are unbounded integers, clipped per instance width.
  bit     mdl_stop;
  int     mdl_stat;
  longint mdl_cyc, mdl_ret, mdl_stall, mdl_misp;

  function automatic bit f_lu();
    return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction
  function automatic bit f_rh();
    return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  endfunction
  function automatic bit f_mp();
    return (E_icode == 4'h7) && (e_cnd == 1'b0);
  endfunction
  function automatic bit is_exc(input logic [3:0] s);
    return (s >= 4'd2) && (s <= 4'd4);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_stop <= 0; mdl_stat <= 1;
      mdl_cyc <= 0; mdl_ret <= 0; mdl_stall <= 0; mdl_misp <= 0;
    end else if (!mdl_stop) begin
      mdl_cyc <= mdl_cyc + 1;
      if (W_stat == 4'd1 && W_icode != 4'd1) mdl_ret <= mdl_ret + 1;
      if (f_lu()) mdl_stall <= mdl_stall + 1;
      if (f_mp()) mdl_misp <= mdl_misp + 1;
      if (is_exc(W_stat)) begin
        mdl_stop <= 1;
        mdl_stat <= int'(W_stat);
      end
    end
  end

  logic [5:0] e_ctl;
  bit         e_db;
  always @(negedge clk) begin
    if (armed) begin
      if (rst) e_ctl = 6'b000111;
      else if (mdl_stop) e_ctl = 6'b111011;
      else begin
        e_db = f_mp() | (f_rh() & !f_lu());
        if (f_lu()) e_db = 0;
        e_ctl = {f_lu() | f_rh(), f_lu(), is_exc(W_stat), e_db, f_mp() | f_lu(),
                 is_exc(m_stat) | is_exc(W_stat)};
      end
      chk("mdl_ctl", 64'(ctl), 64'(e_ctl));
      chk("mdl_ctl_s", 64'(ctl_s), 64'(e_ctl));
      chk("mdl_stat", 64'(cpu_stat), 64'(mdl_stat));
      chk("mdl_halted", 64'(halted), 64'(mdl_stop));
      chk("mdl_halted_s", 64'(halted_s), 64'(mdl_stop));
      chk("mdl_cyc", 64'(cyc_cnt), satv(mdl_cyc, 32));
      chk("mdl_ret", 64'(ret_cnt), satv(mdl_ret, 32));
      chk("mdl_stall", 64'(stall_cnt), satv(mdl_stall, 32));
      chk("mdl_misp", 64'(misp_cnt), satv(mdl_misp, 32));
      chk("mdl_cyc_s", 64'(cyc_s), satv(mdl_cyc, 4));
      chk("mdl_ret_s", 64'(ret_s), satv(mdl_ret, 4));
      chk("mdl_stall_s", 64'(stall_s), satv(mdl_stall, 4));
      chk("mdl_misp_s", 64'(misp_s), satv(mdl_misp, 4));
    end
  end

  task automatic set_idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
    m_stat = 4'h1; W_stat = 4'h1;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    armed = 1;
    chk("rst_ctl", 64'(ctl), 64'h07);
    chk("rst_cyc", 64'(cyc_cnt), 64'd0);
    chk("rst_stat", 64'(cpu_stat), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0;

    // load/use
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1 chk("lu_ctl", 64'(ctl), 64'b110010);
    edge1();
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    chk("lu_cyc", 64'(cyc_cnt), 64'd1);
    set_idle();

    // mispredict
    E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h6;
    #1 chk("misp_ctl", 64'(ctl), 64'b000110);
    edge1();
    chk("misp_cnt", 64'(misp_cnt), 64'd1);
    set_idle();

    // ret walking down D, E, M
    D_icode = 4'h9;
    #1 chk("ret_d_ctl", 64'(ctl), 64'b100100);
    edge1();
    D_icode = 4'h1; E_icode = 4'h9;
    #1 chk("ret_e_ctl", 64'(ctl), 64'b100100);
    edge1();
    E_icode = 4'h1; M_icode = 4'h9;
    #1 chk("ret_m_ctl", 64'(ctl), 64'b100100);
    edge1();
    M_icode = 4'h1;
    #1 chk("ret_end_ctl", 64'(ctl), 64'b000000);
    edge1();
    chk("ret_cyc", 64'(cyc_cnt), 64'd6);

    // retirement: two real instructions, then nops
    W_icode = 4'h6;
    repeat (2) edge1();
    W_icode = 4'h1;
    chk("retire_cnt", 64'(ret_cnt), 64'd2);

    // load/use with a ret in decode: stall wins over bubble
    D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    #1 chk("lu_ret_ctl", 64'(ctl), 64'b110010);
    edge1();
    chk("lu_ret_stall_cnt", 64'(stall_cnt), 64'd2);
    set_idle();

    // memory-stage exception only bubbles M
    m_stat = 4'h3;
    #1 chk("mexc_ctl", 64'(ctl), 64'b000001);
    edge1();
    set_idle();

    // halt
    W_stat = 4'h2;
    #1 chk("halt_run_ctl", 64'(ctl), 64'b001001);
    edge1();
    chk("halt_stat", 64'(cpu_stat), 64'd2);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_cyc", 64'(cyc_cnt), 64'd11);
    W_stat = 4'h1; E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9;
    #1 chk("stop_ctl", 64'(ctl), 64'b111011);
    repeat (3) edge1();
    chk("stop_ctl_hold", 64'(ctl), 64'b111011);
    chk("stop_cyc_frozen", 64'(cyc_cnt), 64'd11);
    chk("stop_stat_hold", 64'(cpu_stat), 64'd2);
    set_idle();

    // saturation on the 4-bit instance
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    repeat (20) edge1();
    chk("sat_cyc_s", 64'(cyc_s), 64'd15);
    chk("sat_cyc", 64'(cyc_cnt), 64'd20);
    edge1();
    chk("sat_cyc_s_hold", 64'(cyc_s), 64'd15);

    // ADR stop, then reset out of STOP
    W_stat = 4'h3;
    edge1();
    W_stat = 4'h1;
    chk("adr_stat", 64'(cpu_stat), 64'd3);
    chk("adr_halted", 64'(halted), 64'd1);
    rst = 1'b1;
    #1 chk("rst_stop_ctl", 64'(ctl), 64'h07);
    edge1();
    chk("rst_stop_stat", 64'(cpu_stat), 64'd1);
    chk("rst_stop_halted", 64'(halted), 64'd0);
    chk("rst_stop_cyc", 64'(cyc_cnt), 64'd0);
    chk("rst_stop_stall", 64'(stall_cnt), 64'd0);
    chk("rst_stop_misp", 64'(misp_cnt), 64'd0);
    chk("rst_stop_ret", 64'(ret_cnt), 64'd0);
    rst = 1'b0;
    edge1();
    chk("post_rst_cyc", 64'(cyc_cnt), 64'd1);
    chk("post_rst_ctl", 64'(ctl), 64'b000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
